// File: rtl/dump_ctrl.sv
// Dump controller: streams one channel's circular sample RAM, oldest sample first, to the UART.
// Optional DUMP_HDR_EN: prefix every dump with the header bytes 0xA5, {5'b0, chan}.
module dump_ctrl #(
   parameter int ENTRIES  = 384,
   parameter int LOG2     = 9,
   parameter int CHANNELS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dump_start,
   input  logic [2:0]            dump_chan,
   input  logic [LOG2-1:0]       waddr,
   input  logic [8*CHANNELS-1:0] rdata,
   input  logic                  tx_done,
   output logic [LOG2-1:0]       raddr,
   output logic                  ren,
   output logic [7:0]            tx_data,
   output logic                  trmt,
   output logic                  busy,
   output logic                  dump_done,
   output logic                  dump_err,
   output logic [2:0]            state_dbg
);

   // Handshake: trmt is a one-cycle strobe that carries tx_data; the byte is owned by the
   // transmitter until tx_done pulses, and only a tx_done seen in HOLD releases the next byte.
   typedef enum logic [2:0] {IDLE, READ, WAIT, XMIT, HOLD, FIN} state_t;

   localparam logic [LOG2-1:0] LAST   = LOG2'(ENTRIES - 1);
   localparam logic [2:0]      MAX_CH = 3'(CHANNELS - 1);

   state_t          state, state_nxt;
   logic [2:0]      chan, chan_nxt;
   logic [LOG2-1:0] cnt, cnt_nxt;
   logic [LOG2-1:0] raddr_nxt;
   logic [7:0]      tx_data_nxt;
   logic            ren_nxt, trmt_nxt, busy_nxt, done_nxt, err_nxt;
`ifdef DUMP_HDR_EN
   // 1: first header byte in flight, 2: second header byte in flight, 0: RAM data phase
   logic [1:0]      hdr, hdr_nxt;
`endif

   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         chan      <= '0;
         cnt       <= '0;
         raddr     <= '0;
         tx_data   <= '0;
         ren       <= 1'b0;
         trmt      <= 1'b0;
         busy      <= 1'b0;
         dump_done <= 1'b0;
         dump_err  <= 1'b0;
`ifdef DUMP_HDR_EN
         hdr       <= '0;
`endif
      end else begin
         state     <= state_nxt;
         chan      <= chan_nxt;
         cnt       <= cnt_nxt;
         raddr     <= raddr_nxt;
         tx_data   <= tx_data_nxt;
         ren       <= ren_nxt;
         trmt      <= trmt_nxt;
         busy      <= busy_nxt;
         dump_done <= done_nxt;
         dump_err  <= err_nxt;
`ifdef DUMP_HDR_EN
         hdr       <= hdr_nxt;
`endif
      end
   end

   // Outputs are registered, so each strobe is raised on the transition into the state it marks.
   always_comb begin
      state_nxt   = state;
      chan_nxt    = chan;
      cnt_nxt     = cnt;
      raddr_nxt   = raddr;
      tx_data_nxt = tx_data;
      busy_nxt    = busy;
      ren_nxt     = 1'b0;
      trmt_nxt    = 1'b0;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;
`ifdef DUMP_HDR_EN
      hdr_nxt     = hdr;
`endif
      case (state)
         IDLE: begin
            if (dump_start) begin
               if (dump_chan <= MAX_CH) begin
                  chan_nxt  = dump_chan;
                  raddr_nxt = (waddr > LAST) ? '0 : waddr;
                  cnt_nxt   = '0;
                  busy_nxt  = 1'b1;
`ifdef DUMP_HDR_EN
                  state_nxt   = XMIT;
                  tx_data_nxt = 8'hA5;
                  trmt_nxt    = 1'b1;
                  hdr_nxt     = 2'd1;
`else
                  state_nxt = READ;
                  ren_nxt   = 1'b1;
`endif
               end else begin
                  err_nxt  = 1'b1;
                  done_nxt = 1'b1;
               end
            end
         end
         READ: state_nxt = WAIT;
         WAIT: begin
            state_nxt   = XMIT;
            tx_data_nxt = rdata[{chan, 3'b000} +: 8];
            trmt_nxt    = 1'b1;
         end
         XMIT: state_nxt = HOLD;
         HOLD: begin
            if (tx_done) begin
`ifdef DUMP_HDR_EN
               if (hdr == 2'd1) begin
                  state_nxt   = XMIT;
                  tx_data_nxt = {5'b0, chan};
                  trmt_nxt    = 1'b1;
                  hdr_nxt     = 2'd2;
               end else if (hdr == 2'd2) begin
                  state_nxt = READ;
                  ren_nxt   = 1'b1;
                  hdr_nxt   = 2'd0;
               end else
`endif
               if (cnt == LAST) begin
                  state_nxt = FIN;
                  done_nxt  = 1'b1;
               end else begin
                  cnt_nxt   = cnt + 1'b1;
                  raddr_nxt = (raddr == LAST) ? '0 : raddr + 1'b1;
                  state_nxt = READ;
                  ren_nxt   = 1'b1;
               end
            end
         end
         FIN: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
